// File: rtl/sw_pe_affine_max.sv
// Smith-Waterman processing element: one query base per PE, affine gap scoring,
// saturating signed arithmetic and a chained best-cell tracker down the array.
module sw_pe_affine_max #(
   parameter int SCORE_W  = 10,
   parameter int CHAR_W   = 2,
   parameter int POS_W    = 12,
   parameter int MATCH    = 2,
   parameter int MISMATCH = 1,
   parameter int GAP_OPEN = 2,
   parameter int GAP_EXT  = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      store_S,
   input  logic [CHAR_W-1:0]         S_in,
   input  logic [POS_W-1:0]          pe_idx,
   input  logic                      valid_in,
   input  logic                      last_in,
   input  logic signed [SCORE_W-1:0] V_in,
   input  logic signed [SCORE_W-1:0] F_in,
   input  logic [CHAR_W-1:0]         T_in,
   input  logic signed [SCORE_W-1:0] max_in,
   input  logic [POS_W-1:0]          row_in,
   input  logic [POS_W-1:0]          col_in,
   output logic                      valid_out,
   output logic                      last_out,
   output logic signed [SCORE_W-1:0] V_out,
   output logic signed [SCORE_W-1:0] F_out,
   output logic [CHAR_W-1:0]         T_out,
   output logic signed [SCORE_W-1:0] max_out,
   output logic [POS_W-1:0]          row_out,
   output logic [POS_W-1:0]          col_out
);

   // Two guard bits are enough to hold any sum/difference before saturation.
   localparam int EW = SCORE_W + 2;

   localparam logic signed [SCORE_W-1:0] S_MIN = {1'b1, {(SCORE_W-1){1'b0}}};
   localparam logic signed [SCORE_W-1:0] S_MAX = {1'b0, {(SCORE_W-1){1'b1}}};
   localparam logic signed [EW-1:0]      X_MIN = {2'b11, S_MIN};
   localparam logic signed [EW-1:0]      X_MAX = {2'b00, S_MAX};
   localparam logic signed [EW-1:0]      X_ZERO     = '0;
   localparam logic signed [EW-1:0]      X_MATCH    = EW'(MATCH);
   localparam logic signed [EW-1:0]      X_MISMATCH = EW'(MISMATCH);
   localparam logic signed [EW-1:0]      X_GAP_OPEN = EW'(GAP_OPEN);
   localparam logic signed [EW-1:0]      X_GAP_EXT  = EW'(GAP_EXT);

   function automatic logic signed [EW-1:0] sx(input logic signed [SCORE_W-1:0] v);
      return {{2{v[SCORE_W-1]}}, v};
   endfunction

   function automatic logic signed [SCORE_W-1:0] sat(input logic signed [EW-1:0] x);
      logic signed [SCORE_W-1:0] r;
      if (x > X_MAX)
         r = S_MAX;
      else if (x < X_MIN)
         r = S_MIN;
      else
         r = x[SCORE_W-1:0];
      return r;
   endfunction

   function automatic logic signed [EW-1:0] max2(input logic signed [EW-1:0] a,
                                                 input logic signed [EW-1:0] b);
      return (a > b) ? a : b;
   endfunction

   logic [CHAR_W-1:0]         s_q;
   logic signed [SCORE_W-1:0] hdiag_q;
   logic signed [SCORE_W-1:0] hleft_q;
   logic signed [SCORE_W-1:0] e_q;
   logic [POS_W-1:0]          col_q;
   logic signed [SCORE_W-1:0] best_q;
   logic [POS_W-1:0]          bcol_q;

   logic signed [EW-1:0]      sub_score;
   logic signed [EW-1:0]      h_cand;
   logic signed [SCORE_W-1:0] e_new;
   logic signed [SCORE_W-1:0] f_new;
   logic signed [SCORE_W-1:0] h_new;
   logic signed [SCORE_W-1:0] best_nxt;
   logic [POS_W-1:0]          bcol_nxt;
   logic                      own_wins;

   always_comb begin
      sub_score = (s_q == T_in) ? X_MATCH : -X_MISMATCH;
      e_new     = sat(max2(sx(hleft_q) - X_GAP_OPEN, sx(e_q) - X_GAP_EXT));
      f_new     = sat(max2(sx(V_in) - X_GAP_OPEN, sx(F_in) - X_GAP_EXT));
      h_cand    = max2(max2(X_ZERO, sx(hdiag_q) + sub_score), max2(sx(e_new), sx(f_new)));
      h_new     = sat(h_cand);
      best_nxt  = best_q;
      bcol_nxt  = bcol_q;
      // Strict compare keeps the earliest column on ties.
      if (h_new > best_q) begin
         best_nxt = h_new;
         bcol_nxt = col_q;
      end
      // Strict compare lets the upstream row win ties in the chain.
      own_wins = best_nxt > max_in;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s_q       <= '0;
         hdiag_q   <= '0;
         hleft_q   <= '0;
         e_q       <= S_MIN;
         col_q     <= '0;
         best_q    <= '0;
         bcol_q    <= '0;
         valid_out <= 1'b0;
         last_out  <= 1'b0;
         V_out     <= '0;
         F_out     <= '0;
         T_out     <= '0;
         max_out   <= '0;
         row_out   <= '0;
         col_out   <= '0;
      end else begin
         valid_out <= 1'b0;
         last_out  <= 1'b0;
         if (store_S) begin
            s_q     <= S_in;
            hdiag_q <= '0;
            hleft_q <= '0;
            e_q     <= S_MIN;
            col_q   <= '0;
            best_q  <= '0;
            bcol_q  <= '0;
         end else if (valid_in) begin
            valid_out <= 1'b1;
            last_out  <= last_in;
            V_out     <= h_new;
            F_out     <= f_new;
            T_out     <= T_in;
            e_q       <= e_new;
            hleft_q   <= h_new;
            hdiag_q   <= V_in;
            col_q     <= col_q + 1'b1;
            best_q    <= best_nxt;
            bcol_q    <= bcol_nxt;
            if (last_in) begin
               if (own_wins) begin
                  max_out <= best_nxt;
                  row_out <= pe_idx;
                  col_out <= bcol_nxt;
               end else begin
                  max_out <= max_in;
                  row_out <= row_in;
                  col_out <= col_in;
               end
            end
         end
      end
   end

endmodule
